// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, ALU op constants
// and small arithmetic helpers.
package md_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // rs1 is treated as two's complement for these ops
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// 32-step restoring divider on unsigned magnitudes; one quotient bit per cycle after i_start.
// Quotient/remainder outputs show the result of the step in progress, final when o_done is high.
module md_div_core
    import md_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;
    logic [31:0] quo_step_s;
    logic [31:0] rem_step_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh_s = {rem_q, quo_q[31]};
        diff_s   = rem_sh_s - {1'b0, dvs_q};
        if (diff_s[32] == 1'b0) begin
            rem_step_s = diff_s[31:0];
            quo_step_s = {quo_q[30:0], 1'b1};
        end else begin
            rem_step_s = rem_sh_s[31:0];
            quo_step_s = {quo_q[30:0], 1'b0};
        end
    end

    // Next-state selection for load / iterate / hold
    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (i_start) begin
            quo_d    = i_dividend;
            rem_d    = 32'd0;
            dvs_d    = i_divisor;
            cnt_d    = 6'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            quo_d = quo_step_s;
            rem_d = rem_step_s;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                active_d = 1'b0;
            end else begin
                active_d = 1'b1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            cnt_q    <= 6'd0;
            active_q <= 1'b0;
        end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign o_done      = active_q && (cnt_q == 6'd31);
    assign o_quotient  = quo_step_s;
    assign o_remainder = rem_step_s;

endmodule

// File: rtl/md_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide, fixed latency.
// Build option MD_FAST_MUL_EN: multiplies bypass iteration through a single-cycle 33x33 multiplier.
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_md_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_md_data
);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        dvz_q, dvz_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, valid_q;

    logic        sgn_a_s, sgn_b_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [63:0] prod_next_s, prod_fix_s;
    logic [31:0] mul_res_s, div_res_s;
    logic        div_start_s, div_done_s;
    logic [31:0] div_quo_s, div_rem_s;

    assign sgn_a_s     = op_signed_a(i_md_op) & i_operand_a[31];
    assign sgn_b_s     = op_signed_b(i_md_op) & i_operand_b[31];
    assign mag_a_s     = cond_neg32(i_operand_a, sgn_a_s);
    assign mag_b_s     = cond_neg32(i_operand_b, sgn_b_s);
    assign prod_next_s = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign prod_fix_s  = (sa_q ^ sb_q) ? (~prod_next_s + 64'd1) : prod_next_s;
    assign mul_res_s   = (op_q == MD_MUL) ? prod_fix_s[31:0] : prod_fix_s[63:32];

    md_div_core u_div (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (div_start_s),
        .i_dividend  (mag_a_s),
        .i_divisor   (mag_b_s),
        .o_done      (div_done_s),
        .o_quotient  (div_quo_s),
        .o_remainder (div_rem_s)
    );

    // Sign fix-up of the magnitude result; a zero divisor forces an all-ones quotient
    always_comb begin
        case (op_q)
            MD_DIV:  div_res_s = dvz_q ? 32'hFFFF_FFFF : cond_neg32(div_quo_s, sa_q ^ sb_q);
            MD_DIVU: div_res_s = dvz_q ? 32'hFFFF_FFFF : div_quo_s;
            MD_REM:  div_res_s = cond_neg32(div_rem_s, sa_q);
            MD_REMU: div_res_s = div_rem_s;
            default: div_res_s = 32'd0;
        endcase
    end

`ifdef MD_FAST_MUL_EN
    logic signed [65:0] fast_prod_s;
    logic        [31:0] fast_res_s;

    assign fast_prod_s = $signed({sgn_a_s & i_operand_a[31], i_operand_a})
                       * $signed({sgn_b_s & i_operand_b[31], i_operand_b});
    assign fast_res_s  = (i_md_op == MD_MUL) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`endif

    // FSM next state plus datapath next values
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        dvz_d       = dvz_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        result_d    = result_q;
        div_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    op_d        = md_op_e'(i_md_op);
                    sa_d        = sgn_a_s;
                    sb_d        = sgn_b_s;
                    dvz_d       = (i_operand_b == 32'd0);
                    prod_d      = 64'd0;
                    mcand_d     = {32'd0, mag_a_s};
                    mplier_d    = mag_b_s;
                    cnt_d       = 6'd0;
                    div_start_s = i_md_op[2];
`ifdef MD_FAST_MUL_EN
                    if (!i_md_op[2]) begin
                        state_d  = ST_DONE;
                        result_d = fast_res_s;
                    end else begin
                        state_d = ST_CALC;
                    end
`else
                    state_d = ST_CALC;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                prod_d   = prod_next_s;
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                if (cnt_q == 6'd31) begin
                    state_d = ST_DONE;
                    cnt_d   = 6'd0;
                    if (!op_q[2]) begin
                        result_d = mul_res_s;
                    end else if (div_done_s) begin
                        result_d = div_res_s;
                    end else begin
                        result_d = result_q;
                    end
                end else begin
                    state_d = ST_CALC;
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any in-flight operation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= 6'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dvz_q    <= 1'b0;
            prod_q   <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dvz_q    <= dvz_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            busy_q   <= (state_d != ST_IDLE);
            valid_q  <= (state_d == ST_DONE);
        end
    end

    assign o_busy    = busy_q;
    assign o_valid   = valid_q;
    assign o_md_data = result_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: reset state, every op, divide corner cases, busy-time i_start,
// mid-operation reset. Cycle 1 is the cycle right after the accepting edge.
module tb_md_unit;
    import md_pkg::*;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        valid;
    logic [31:0] md_data;

    int n_assert;
    int n_fail;

    md_unit #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_md_op     (md_op),
        .i_operand_a (opa),
        .i_operand_b (opb),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_md_data   (md_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, optionally poke i_start while busy,
    // then check latency, result, busy window, single-cycle valid and result hold.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc,
                          input bit poke);
        int  cyc;
        bit  found;
        bit  busy_ok;
        start = 1'b1;
        md_op = op;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        md_op   = ~op;
        opa     = ~a;
        opb     = b ^ 32'h0000_5A5A;
        cyc     = 1;
        found   = 1'b0;
        busy_ok = 1'b1;
        while (!found && cyc <= 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (valid === 1'b1) begin
                found = 1'b1;
            end else begin
                if (poke && cyc == 5) begin
                    start = 1'b1;
                    md_op = MD_MUL;
                    opa   = 32'd3;
                    opb   = 32'd5;
                end
                if (poke && cyc == 8) start = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " result"}, md_data, exp);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, {31'd0, valid}, 32'd0);
        check({tag, " hold"}, md_data, exp);
    endtask

    initial begin
        int vcount;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        md_op    = 3'b000;
        opa      = 32'd0;
        opb      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst valid", {31'd0, valid}, 32'd0);
        check("rst data", md_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("MUL 7*-3",      MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_CYC, 1'b0);
        run_op("MULH min*min",  MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_CYC, 1'b0);
        run_op("MULHU max*max", MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_CYC, 1'b0);
        run_op("MULHSU -1*max", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYC, 1'b0);
        run_op("MULH -5*7",     MD_MULH,   32'hFFFF_FFFB, 32'h0000_0007, 32'hFFFF_FFFF, MUL_CYC, 1'b0);
        run_op("MUL big",       MD_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, MUL_CYC, 1'b0);
        run_op("DIV -7/2",      MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_CYC, 1'b0);
        run_op("REM -7%2",      MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_CYC, 1'b0);
        run_op("DIVU 100/7",    MD_DIVU,   32'd100,       32'd7,         32'd14,        DIV_CYC, 1'b0);
        run_op("REMU 100%7",    MD_REMU,   32'd100,       32'd7,         32'd2,         DIV_CYC, 1'b0);
        run_op("DIVU x/0",      MD_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, DIV_CYC, 1'b0);
        run_op("REM x%0",       MD_REM,    32'h0000_1234, 32'd0,         32'h0000_1234, DIV_CYC, 1'b0);
        run_op("DIV -5/0",      MD_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, DIV_CYC, 1'b0);
        run_op("REMU -5%0",     MD_REMU,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, DIV_CYC, 1'b0);
        run_op("DIV ovf",       MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_CYC, 1'b0);
        run_op("REM ovf",       MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_CYC, 1'b0);
        run_op("DIV 20/-3",     MD_DIV,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, DIV_CYC, 1'b0);
        run_op("REM 20%-3",     MD_REM,    32'd20,        32'hFFFF_FFFD, 32'h0000_0002, DIV_CYC, 1'b0);
        run_op("DIVU poke",     MD_DIVU,   32'd1000,      32'd10,        32'd100,       DIV_CYC, 1'b1);

        // Abort a DIV at cycle 10 with reset
        start = 1'b1;
        md_op = MD_DIV;
        opa   = 32'd100;
        opb   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort valid", {31'd0, valid}, 32'd0);
        check("abort data", md_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) vcount++;
        end
        check("abort no valid", vcount, 32'd0);
        run_op("DIVU 9/3", MD_DIVU, 32'd9, 32'd3, 32'd3, DIV_CYC, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
